// File: rtl/axi_pkg.sv
// Shared AXI3 write-path definitions: response codes, burst type,
// status-word byte lanes and scheduler state encoding.
package axi_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam int unsigned STAT_LSB_OK     = 0;
    localparam int unsigned STAT_LSB_EXOK   = 8;
    localparam int unsigned STAT_LSB_SLVERR = 16;
    localparam int unsigned STAT_LSB_DECERR = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } sched_state_t;

    // Byte lane of the status word that counts a given response code
    function automatic int unsigned stat_lsb(input logic [1:0] resp);
        case (resp)
            BRESP_OKAY:   return STAT_LSB_OK;
            BRESP_EXOKAY: return STAT_LSB_EXOK;
            BRESP_SLVERR: return STAT_LSB_SLVERR;
            default:      return STAT_LSB_DECERR;
        endcase
    endfunction

endpackage

// File: rtl/axi_resp_stat.sv
// B-channel response statistics: four saturating per-class byte counters
// packed into one status word, plus a sticky unexpected-response flag.
module axi_resp_stat
    import axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_bvalid,
    input  logic        i_bready,
    input  logic [1:0]  i_bresp,
    input  logic        i_outst_zero,
    output logic        o_hs,
    output logic [31:0] o_stat,
    output logic        o_proto_err
);

    logic [7:0] r_cnt [4];
    logic       r_proto_err;
    logic       w_hs;
    logic [31:0] w_stat;

    assign w_hs = i_bvalid & i_bready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
            r_proto_err <= 1'b0;
        end else if (w_hs) begin
            if (r_cnt[i_bresp] != '1) begin
                r_cnt[i_bresp] <= r_cnt[i_bresp] + 8'd1;
            end
            if (i_outst_zero) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_stat = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_stat[stat_lsb(2'(i)) +: 8] = r_cnt[i];
        end
    end

    assign o_hs        = w_hs;
    assign o_stat      = w_stat;
    assign o_proto_err = r_proto_err;

endmodule

// File: rtl/axi_write_sched.sv
// Two-requester AXI3 write scheduler: round-robin burst grant, AW-then-W
// sequencing with combinational data forwarding, outstanding tracking and B routing.
module axi_write_sched
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [ADDR_W-1:0]   req_addr0,
    input  logic [ADDR_W-1:0]   req_addr1,
    input  logic [3:0]          req_len0,
    input  logic [3:0]          req_len1,
    output logic [1:0]          req_ready,
    input  logic [DATA_W-1:0]   wd_data0,
    input  logic [DATA_W-1:0]   wd_data1,
    input  logic [1:0]          wd_valid,
    output logic [1:0]          wd_ready,
    output logic [1:0]          done,
    output logic [1:0]          done_resp,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [3:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awid,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wid,
    output logic                wvalid,
    input  logic                wready,
    input  logic                bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [3:0]          outst,
    output logic [31:0]         stat,
    output logic                proto_err
);

    localparam logic [2:0] AWSIZE = 3'($clog2(DATA_W / 8));
    localparam logic [3:0] MAX_O  = 4'(MAX_OUTST);

    sched_state_t       r_state;
    logic               r_rr;
    logic               r_id;
    logic [ADDR_W-1:0]  r_addr;
    logic [3:0]         r_len;
    logic [3:0]         r_beat;
    logic               r_awvalid;
    logic [3:0]         r_outst;
    logic               r_bready;
    logic [1:0]         r_done;
    logic [1:0]         r_done_resp;

    logic               w_can_grant;
    logic               w_gnt_id;
    logic               w_aw_hs;
    logic               w_wvalid;
    logic               w_w_hs;
    logic               w_wlast;
    logic               w_b_hs;

    // r_rr names the requester that wins when both are asking
    assign w_can_grant = (r_state == ST_IDLE) && (|req_valid) && (r_outst < MAX_O);
    assign w_gnt_id    = req_valid[r_rr] ? r_rr : ~r_rr;
    assign w_aw_hs     = r_awvalid & awready;
    assign w_wvalid    = (r_state == ST_DATA) & wd_valid[r_id];
    assign w_w_hs      = w_wvalid & wready;
    assign w_wlast     = (r_state == ST_DATA) && (r_beat == r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b0;
            r_id      <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_awvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_can_grant) begin
                        r_addr    <= w_gnt_id ? req_addr1 : req_addr0;
                        r_len     <= w_gnt_id ? req_len1 : req_len0;
                        r_id      <= w_gnt_id;
                        r_rr      <= ~w_gnt_id;
                        r_awvalid <= 1'b1;
                        r_state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (awready) begin
                        r_awvalid <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_w_hs) begin
                        if (w_wlast) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_beat <= r_beat + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Simultaneous AW and B cancel; a stray B never drives the count below zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outst <= '0;
        end else begin
            case ({w_aw_hs, w_b_hs})
                2'b10:   r_outst <= r_outst + 4'd1;
                2'b01:   if (r_outst != '0) r_outst <= r_outst - 4'd1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bready    <= 1'b0;
            r_done      <= '0;
            r_done_resp <= '0;
        end else begin
            r_bready <= 1'b1;
            r_done   <= w_b_hs ? (2'b01 << bid) : 2'b00;
            if (w_b_hs) begin
                r_done_resp <= bresp;
            end
        end
    end

    axi_resp_stat u_resp_stat (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bvalid     (bvalid),
        .i_bready     (r_bready),
        .i_bresp      (bresp),
        .i_outst_zero (r_outst == '0),
        .o_hs         (w_b_hs),
        .o_stat       (stat),
        .o_proto_err  (proto_err)
    );

    assign req_ready = w_can_grant ? (2'b01 << w_gnt_id) : 2'b00;
    assign wd_ready  = ((r_state == ST_DATA) && wready) ? (2'b01 << r_id) : 2'b00;
    assign awaddr    = r_addr;
    assign awlen     = r_len;
    assign awsize    = AWSIZE;
    assign awburst   = BURST_INCR;
    assign awid      = r_id;
    assign awvalid   = r_awvalid;
    assign wdata     = r_id ? wd_data1 : wd_data0;
    assign wstrb     = '1;
    assign wlast     = w_wlast;
    assign wid       = r_id;
    assign wvalid    = w_wvalid;
    assign bready    = r_bready;
    assign done      = r_done;
    assign done_resp = r_done_resp;
    assign outst     = r_outst;

endmodule

// File: tb/tb_axi_write_sched.sv
// Bench for axi_write_sched: transaction-level model checked every cycle,
// directed scenarios with hand-computed literal expectations.
module tb_axi_write_sched;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [AW-1:0] req_addr0 = '0, req_addr1 = '0;
    logic [3:0]    req_len0 = '0, req_len1 = '0;
    logic [1:0]    req_ready;
    logic [DW-1:0] wd_data0, wd_data1;
    logic [1:0]    wd_valid = '0;
    logic [1:0]    wd_ready;
    logic [1:0]    done, done_resp;
    logic [AW-1:0] awaddr;
    logic [3:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awid, awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wlast, wid, wvalid;
    logic          wready = 1'b0;
    logic          bid = 1'b0;
    logic [1:0]    bresp = '0;
    logic          bvalid = 1'b0;
    logic          bready;
    logic [3:0]    outst;
    logic [31:0]   stat;
    logic          proto_err;

    always #5 clk = ~clk;

    axi_write_sched #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_len0(req_len0), .req_len1(req_len1), .req_ready(req_ready),
        .wd_data0(wd_data0), .wd_data1(wd_data1), .wd_valid(wd_valid), .wd_ready(wd_ready),
        .done(done), .done_resp(done_resp),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awid(awid), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .outst(outst), .stat(stat), .proto_err(proto_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each requester streams a self-identifying pattern: its index and beat number
    function automatic logic [63:0] pat(input int unsigned id, input int unsigned k);
        return {24'hDA7A00, 8'(id), 16'h0000, 16'(k)};
    endfunction

    int unsigned src_cnt [2];
    assign wd_data0 = pat(0, src_cnt[0]);
    assign wd_data1 = pat(1, src_cnt[1]);

    // Model state
    int unsigned   m_outst;
    int unsigned   m_cnt [4];
    logic          m_proto;
    logic [1:0]    m_done, m_resp;
    logic          m_busy, m_awpend, m_wphase;
    int unsigned   m_prio;
    logic [31:0]   m_cur_addr;
    int unsigned   m_cur_len, m_cur_id, m_beat;
    int unsigned   m_wcnt [2];
    logic [1:0]    m_whs;
    int unsigned   grant_log [$];
    int unsigned   cnt_aw, cnt_w, cnt_wlast;

    logic [1:0]    t_exp_rr;
    logic          t_exp_wv, t_gp, t_aw_hs, t_b_hs;
    int unsigned   t_g;

    function automatic logic [31:0] exp_stat();
        return {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]};
    endfunction

    task automatic model_reset();
        m_outst = 0; m_proto = 0; m_done = '0; m_resp = '0;
        m_busy = 0; m_awpend = 0; m_wphase = 0; m_prio = 0;
        m_cur_addr = '0; m_cur_len = 0; m_cur_id = 0; m_beat = 0;
        m_whs = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        for (int i = 0; i < 2; i++) m_wcnt[i] = 0;
        grant_log.delete();
        cnt_aw = 0; cnt_w = 0; cnt_wlast = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_cnt[0] <= 0;
            src_cnt[1] <= 0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (m_whs[i]) src_cnt[i] <= src_cnt[i] + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_awvalid", awvalid, 0);
            chk("rst_wvalid", wvalid, 0);
            chk("rst_wd_ready", wd_ready, 0);
            chk("rst_done", done, 0);
            chk("rst_outst", outst, 0);
            chk("rst_stat", stat, 0);
            chk("rst_proto_err", proto_err, 0);
        end else begin
            chk("outst", outst, m_outst);
            chk("stat", stat, exp_stat());
            chk("proto_err", proto_err, m_proto);
            chk("done", done, m_done);
            if (m_done != 0) chk("done_resp", done_resp, m_resp);

            t_gp = !m_busy && (req_valid != 0) && (m_outst < MO);
            if (!t_gp) t_exp_rr = 2'b00;
            else if (req_valid[m_prio]) t_exp_rr = 2'b01 << m_prio;
            else t_exp_rr = 2'b01 << (1 - m_prio);
            chk("req_ready", req_ready, t_exp_rr);

            chk("awvalid", awvalid, m_awpend);
            if (m_awpend) begin
                chk("awaddr", awaddr, m_cur_addr);
                chk("awlen", awlen, m_cur_len);
                chk("awid", awid, m_cur_id);
                chk("awsize", awsize, 3);
                chk("awburst", awburst, 1);
            end

            t_exp_wv = m_wphase && wd_valid[m_cur_id];
            chk("wvalid", wvalid, t_exp_wv);
            chk("wd_ready", wd_ready, (m_wphase && wready) ? (2'b01 << m_cur_id) : 2'b00);
            if (m_wphase) begin
                chk("wid", wid, m_cur_id);
                chk("wlast", wlast, m_beat == m_cur_len);
                if (t_exp_wv) begin
                    chk("wdata", wdata, pat(m_cur_id, m_wcnt[m_cur_id]));
                    chk("wstrb", wstrb, 8'hFF);
                end
            end
            if (bvalid) chk("bready", bready, 1);

            if (awvalid) cnt_aw++;
            if (wvalid && wready) begin
                cnt_w++;
                if (wlast) cnt_wlast++;
            end

            m_whs = '0;
            m_done = '0;
            t_aw_hs = 0;
            t_b_hs = bvalid && bready;
            if (t_b_hs) begin
                m_done = 2'b01 << bid;
                m_resp = bresp;
                if (m_cnt[bresp] < 255) m_cnt[bresp]++;
                if (m_outst == 0) m_proto = 1;
            end
            if (t_exp_rr != 0) begin
                t_g = t_exp_rr[1] ? 1 : 0;
                m_cur_addr = (t_g == 1) ? req_addr1 : req_addr0;
                m_cur_len  = (t_g == 1) ? req_len1 : req_len0;
                m_cur_id   = t_g;
                m_busy = 1;
                m_awpend = 1;
                m_prio = 1 - t_g;
                grant_log.push_back(t_g);
            end else if (m_awpend && awready) begin
                t_aw_hs = 1;
                m_awpend = 0;
                m_wphase = 1;
                m_beat = 0;
            end else if (t_exp_wv && wready) begin
                m_whs[m_cur_id] = 1'b1;
                m_wcnt[m_cur_id]++;
                if (m_beat == m_cur_len) begin
                    m_wphase = 0;
                    m_busy = 0;
                end else begin
                    m_beat++;
                end
            end
            if (t_aw_hs && !t_b_hs) m_outst++;
            else if (t_b_hs && !t_aw_hs && m_outst > 0) m_outst--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; wd_valid = '0; awready = 0; wready = 0; bvalid = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic issue(input int id, input logic [31:0] addr, input logic [3:0] len);
        if (id == 0) begin req_addr0 = addr; req_len0 = len; end
        else begin req_addr1 = addr; req_len1 = len; end
        req_valid[id] = 1'b1;
        #1;
        for (int n = 0; n < 50; n++) begin
            if (req_ready[id]) begin
                tick();
                req_valid[id] = 1'b0;
                return;
            end
            tick();
        end
        req_valid[id] = 1'b0;
        checks++; errors++;
        $display("FAIL issue%0d: req_ready got 0 expected 1 within 50 cycles", id);
    endtask

    task automatic wait_quiet(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (!m_busy) return;
            tick();
        end
        checks++; errors++;
        $display("FAIL burst_timeout: still busy, expected idle within %0d cycles", budget);
    endtask

    task automatic send_b(input logic id, input logic [1:0] resp);
        bid = id; bresp = resp; bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
    endtask

    int unsigned exp_seq [4] = '{0, 1, 0, 1};

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (2) tick();
        chk("reset_outst", outst, 0);
        chk("reset_stat", stat, 0);
        chk("reset_awvalid", awvalid, 0);
        chk("reset_bready", bready, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("bready_after_reset", bready, 1);

        // Single burst
        awready = 1; wready = 1; wd_valid = 2'b01;
        issue(0, 32'h1000, 4'd3);
        wait_quiet(40);
        chk("single_aw_cycles", cnt_aw, 1);
        chk("single_w_beats", cnt_w, 4);
        chk("single_wlast", cnt_wlast, 1);
        chk("single_outst", outst, 1);
        send_b(1'b0, 2'b00);
        chk("single_done", done, 2'b01);
        chk("single_done_resp", done_resp, 2'b00);
        chk("single_stat", stat, 32'h0000_0001);
        tick();
        chk("single_outst_after_b", outst, 0);

        // Round-robin with both requesters asking continuously
        do_reset();
        awready = 1; wready = 1; wd_valid = 2'b11;
        req_addr0 = 32'h2000; req_addr1 = 32'h3000; req_len0 = 0; req_len1 = 0;
        req_valid = 2'b11;
        repeat (30) tick();
        chk("rr_outst_full", outst, 4);
        chk("rr_grants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (grant_log.size() > i) chk("rr_order", grant_log[i], exp_seq[i]);
        chk("rr_stall_ready", req_ready, 0);
        send_b(1'b1, 2'b00);
        repeat (10) tick();
        chk("rr_one_more_grant", grant_log.size(), 5);
        if (grant_log.size() > 4) chk("rr_fifth", grant_log[4], 0);
        chk("rr_outst_refill", outst, 4);
        req_valid = 2'b00;
        repeat (4) send_b(1'b0, 2'b00);
        tick();
        chk("rr_drain_outst", outst, 0);
        chk("rr_proto", proto_err, 0);

        // Backpressure on AW and W
        do_reset();
        wd_valid = 2'b01;
        issue(0, 32'h4000, 4'd7);
        repeat (5) tick();
        chk("bp_aw_held", awvalid, 1);
        chk("bp_awaddr", awaddr, 32'h4000);
        awready = 1;
        for (int n = 0; n < 80; n++) begin
            wready = ~wready;
            tick();
            if (!m_busy) break;
        end
        chk("bp_aw_cycles", cnt_aw, 6);
        chk("bp_w_beats", cnt_w, 8);
        chk("bp_wlast", cnt_wlast, 1);
        chk("bp_outst", outst, 1);

        // Simultaneous AW and B handshakes, then error responses
        do_reset();
        awready = 1; wready = 1; wd_valid = 2'b11;
        issue(0, 32'h100, 4'd0); wait_quiet(20);
        issue(1, 32'h200, 4'd0); wait_quiet(20);
        chk("sim_outst_pre", outst, 2);
        awready = 0;
        issue(0, 32'h300, 4'd0);
        awready = 1; bid = 0; bresp = 2'b10; bvalid = 1;
        tick();
        bvalid = 0;
        chk("sim_outst_same", outst, 2);
        wait_quiet(20);
        send_b(1'b1, 2'b10);
        send_b(1'b0, 2'b11);
        issue(1, 32'h400, 4'd0); wait_quiet(20);
        send_b(1'b1, 2'b10);
        tick();
        chk("err_stat", stat, 32'h0103_0000);
        chk("err_outst", outst, 0);
        chk("err_proto", proto_err, 0);

        // Saturation and stray responses
        do_reset();
        bresp = 2'b00; bvalid = 1;
        for (int n = 0; n < 300; n++) begin
            bid = 1'(n);
            tick();
        end
        bvalid = 0;
        tick();
        chk("sat_stat", stat, 32'h0000_00FF);
        chk("sat_proto", proto_err, 1);
        chk("sat_outst", outst, 0);

        // Reset in the middle of a data phase
        do_reset();
        send_b(1'b1, 2'b11);
        tick();
        chk("pre_rst_stat", stat, 32'h0100_0000);
        chk("pre_rst_proto", proto_err, 1);
        awready = 1; wready = 1;
        issue(1, 32'h5000, 4'd7);
        wd_valid = 2'b10;
        for (int n = 0; n < 40; n++) begin
            if (cnt_w >= 2) break;
            tick();
        end
        chk("mid_beats", cnt_w, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_wvalid", wvalid, 0);
        chk("mid_rst_wd_ready", wd_ready, 0);
        chk("mid_rst_outst", outst, 0);
        chk("mid_rst_stat", stat, 0);
        chk("mid_rst_proto", proto_err, 0);
        chk("mid_rst_bready", bready, 0);
        wd_valid = 2'b00;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        wd_valid = 2'b01;
        issue(0, 32'h6000, 4'd1);
        wait_quiet(20);
        send_b(1'b0, 2'b01);
        chk("fresh_done", done, 2'b01);
        chk("fresh_done_resp", done_resp, 2'b01);
        chk("fresh_stat", stat, 32'h0000_0100);
        chk("fresh_outst", outst, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule

// File: doc/axi_write_sched.md
Name: axi_write_sched

Overview:
- Two-requester AXI3 write-channel scheduler for the OCM write path. Arbitrates write bursts from two local sources, sequences the AW and W channels, tracks outstanding transactions and routes each B response back to its originator.
- Keeps per-class response statistics in the same packed-byte status format as the existing write-response monitor, so software reads both with the same decode.

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 64, AXI data width; wstrb is DATA_W/8 bits
- MAX_OUTST, 4, maximum AW-issued-but-unresponded bursts (1..15)

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester burst request
- req_addr0, req_addr1  in  ADDR_W  burst start address
- req_len0, req_len1  in  4  AXI3 awlen (beats-1)
- req_ready  out  2  request accepted (one-hot, one cycle)
- wd_data0, wd_data1  in  DATA_W  per-requester write data
- wd_valid  in  2  data beat valid
- wd_ready  out  2  data beat taken
- done  out  2  burst-complete pulse to requester
- done_resp  out  2  bresp of completed burst
- awaddr  out  ADDR_W; awlen  out  4; awsize  out  3 (log2(DATA_W/8)); awburst  out  2 (INCR = 01); awid  out  1; awvalid  out  1; awready  in  1
- wdata  out  DATA_W; wstrb  out  DATA_W/8 (all ones); wlast  out  1; wid  out  1; wvalid  out  1; wready  in  1
- bid  in  1; bresp  in  2; bvalid  in  1; bready  out  1
- outst  out  4  current outstanding count
- stat  out  32  {decerr, slverr, exok, ok}, 8 bits each
- proto_err  out  1  sticky: B with no outstanding burst

Behaviour:
- Reset (async, rst_n low): FSM = IDLE, rr pointer = 0, outst = 0, stat = 0, proto_err = 0. All valid, ready and done outputs are 0. bready is 1 immediately after reset release.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_valid is set and outst < MAX_OUTST, grant round-robin. The priority holder is the requester not granted last; after reset requester 0 has priority.
  - The grant latches addr, len and id (= requester index).
  - req_ready[g] pulses in the same cycle. Next state is ADDR.
  - When outst == MAX_OUTST, no grant is made and req_ready stays 0.
- ADDR:
  - awvalid = 1 with the latched fields, held stable until awready.
  - On handshake: outst increments, beat counter clears, next state is DATA.
- DATA:
  - wvalid = wd_valid[g]; wd_ready[g] = wready. Data is combinationally forwarded, so there is zero added latency per beat.
  - wid = g; wlast = 1 when beat counter == latched len.
  - On each W handshake the beat counter increments. On the wlast handshake the FSM returns to IDLE, and the next grant is possible in that IDLE cycle.
  - The non-granted requester always sees wd_ready = 0.
- AW always precedes its W data; bursts never interleave.
- B channel (independent of the FSM):
  - On bvalid && bready: done[bid] = 1 for one cycle and done_resp = bresp, registered (1-cycle latency).
  - Increment the stat byte selected by bresp. Each byte saturates at 255 (no wrap).
- outst update:
  - AW handshake and B handshake in the same cycle: outst unchanged.
  - B handshake with outst == 0: outst stays 0, proto_err set, stat still counts, done still pulses.
- proto_err clears only on reset.
- Reset asserted mid-burst: everything returns to reset values immediately. Upstream AXI is expected to be reset together.
- req_* sampled only at the grant; changes afterwards are ignored.

Decomposition:
- Shared package axi_pkg holds:
  - BRESP_OKAY/EXOKAY/SLVERR/DECERR encodings
  - BURST_INCR constant
  - the stat byte-lane offsets (ok = [7:0] ... decerr = [31:24])
  - FSM state encoding
- One natural sub-module: axi_resp_stat. It owns the B-handshake decode, the four saturating 8-bit counters and proto_err, and is reusable by the read path.

Test Plan:
- Single burst: req0 at addr 0x1000, len=3, awready and wready held high → awvalid one cycle, 4 W beats with wlast on beat 4, wid=0. bresp=00 → done[0] pulses, stat=0x00000001.
- Round-robin: both req_valid held continuously, len=0 each → grants alternate 0,1,0,1. awid follows grant, outst climbs to 4 and holds. req_ready stays 0 until a B arrives, then exactly one new grant.
- Backpressure: awready low 5 cycles, then wready toggling every other cycle during len=7 → AW fields stable, exactly 8 W handshakes, wlast only on the 8th, no data lost.
- Simultaneous AW and B handshake at outst=2 → outst stays 2. Error responses bresp=10 ×3 and 11 ×1 → stat=0x01030000.
- Saturation and protocol error: 300 OKAY responses → ok byte = 0xFF. B with outst=0 → proto_err=1, outst=0.
- Reset mid-DATA after beat 2 of len=7 → all outputs 0, FSM IDLE, stat=0. A fresh request after release completes normally.
